// File: rtl/ms_delay_scheduler.sv
// Shares one 1 ms timebase among NCH delay requesters. Each channel queues one
// request, gets a round-robin load grant, counts down on ticks and pulses done.
module ms_delay_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    cancel,
    input  logic [NCH*DW-1:0] dly,
    output logic              timer_en,
    output logic [NCH-1:0]    grant,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    localparam int RW = $clog2(NCH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state      [NCH];
    state_t        state_nxt  [NCH];
    logic [DW-1:0] shadow     [NCH];
    logic [DW-1:0] shadow_nxt [NCH];
    logic [DW-1:0] count      [NCH];
    logic [DW-1:0] count_nxt  [NCH];
    logic [RW-1:0] rr;
    logic [RW-1:0] rr_nxt;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] cand;
    logic [NCH-1:0] win_oh;
    logic [NCH-1:0] grant_nxt;
    logic [NCH-1:0] done_nxt;

    // Status decode and arbitration; busy/timer_en come from state registers only.
    always_comb begin
        pend   = '0;
        busy   = '0;
        win_oh = '0;
        rr_nxt = rr;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = (state[i] == ST_PEND);
            busy[i] = (state[i] != ST_IDLE);
        end
        timer_en = |busy;
        cand     = pend & ~cancel;
        // First pass picks the lowest candidate overall (wrap-around case);
        // the second pass overrides it with the lowest candidate at or above rr.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                rr_nxt    = (i == NCH - 1) ? '0 : RW'(i + 1);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i] && (RW'(i) >= rr)) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                rr_nxt    = (i == NCH - 1) ? '0 : RW'(i + 1);
            end
        end
    end

    // Per-channel next state. Cancel has priority over request, grant and tick.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nxt[i]  = state[i];
            shadow_nxt[i] = shadow[i];
            count_nxt[i]  = count[i];
            grant_nxt[i]  = 1'b0;
            done_nxt[i]   = 1'b0;
            if (cancel[i]) begin
                state_nxt[i] = ST_IDLE;
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        if (req[i]) begin
                            state_nxt[i]  = ST_PEND;
                            shadow_nxt[i] = dly[i*DW +: DW];
                        end
                    end
                    ST_PEND: begin
                        if (win_oh[i]) begin
                            grant_nxt[i] = 1'b1;
                            if (shadow[i] != '0) begin
                                state_nxt[i] = ST_RUN;
                                count_nxt[i] = shadow[i];
                            end else begin
                                state_nxt[i] = ST_IDLE;
                                done_nxt[i]  = 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            count_nxt[i] = count[i] - 1'b1;
                            if (count[i] == DW'(1)) begin
                                state_nxt[i] = ST_IDLE;
                                done_nxt[i]  = 1'b1;
                            end
                        end
                    end
                    default: state_nxt[i] = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the per-channel
    // register arrays are plain flops, so they are reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr    <= '0;
            grant <= '0;
            done  <= '0;
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= ST_IDLE;
                shadow[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            rr    <= rr_nxt;
            grant <= grant_nxt;
            done  <= done_nxt;
            for (int i = 0; i < NCH; i++) begin
                state[i]  <= state_nxt[i];
                shadow[i] <= shadow_nxt[i];
                count[i]  <= count_nxt[i];
            end
        end
    end

endmodule
